ul_n_seq: RTL and testbench



---
 rtl/ul_n_seq_if.sv | 37 +++
 rtl/ul_n_seq.sv | 169 ++++++++++++++++
 tb/tb_ul_n_seq.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ul_n_seq_if.sv
// Start/busy/done bus for ul_n_seq; the acc request bit exists only when UL_N_SEQ_ACC_EN is defined.
// Handshake: the master raises start with op/a/b (and acc) valid; the slave samples them on a rising
// edge only while busy=0, and pulses done for one cycle when out and the flags have been updated.
interface ul_n_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef UL_N_SEQ_ACC_EN
  logic             acc;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             neg;
  logic             carry;
  logic             ovf;

  modport master (
`ifdef UL_N_SEQ_ACC_EN
    output acc,
`endif
    output start, op, a, b,
    input  busy, done, out, zero, neg, carry, ovf
  );

  modport slave (
`ifdef UL_N_SEQ_ACC_EN
    input  acc,
`endif
    input  start, op, a, b,
    output busy, done, out, zero, neg, carry, ovf
  );
endinterface

// File: rtl/ul_n_seq.sv
// Registered WIDTH-bit logic/arithmetic/shift unit: single-cycle logic/add/sub, iterative SHL/ROR.
// Optional macro UL_N_SEQ_ACC_EN adds acc chaining (operand a replaced by the current out register).
module ul_n_seq #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  ul_n_seq_if.slave  bus,
  output logic       o_dbg_state
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_count, w_count_nxt;
  logic [WIDTH-1:0] r_work, w_work_nxt;
  logic             r_rot, w_rot_nxt;
  logic [WIDTH-1:0] r_out, w_out_nxt;
  logic             r_zero, w_zero_nxt;
  logic             r_neg, w_neg_nxt;
  logic             r_carry, w_carry_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;

  logic [WIDTH-1:0] w_opa;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [CW-1:0]    w_cnt_in;
  logic [WIDTH-1:0] w_step;
  logic             w_step_out;
  logic [WIDTH-1:0] w_res;
  logic             w_res_c;
  logic             w_res_v;
  logic             w_fin;

`ifdef UL_N_SEQ_ACC_EN
  assign w_opa = bus.acc ? r_out : bus.a;
`else
  assign w_opa = bus.a;
`endif

  // SUB as a + ~b + 1 so the top bit is the no-borrow flag directly.
  assign w_sum    = {1'b0, w_opa} + {1'b0, bus.b};
  assign w_diff   = {1'b0, w_opa} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
  assign w_cnt_in = bus.b[CW-1:0];

  assign w_step     = r_rot ? {r_work[0], r_work[WIDTH-1:1]} : {r_work[WIDTH-2:0], 1'b0};
  assign w_step_out = r_rot ? r_work[0] : r_work[WIDTH-1];

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_work_nxt  = r_work;
    w_rot_nxt   = r_rot;
    w_out_nxt   = r_out;
    w_zero_nxt  = r_zero;
    w_neg_nxt   = r_neg;
    w_carry_nxt = r_carry;
    w_ovf_nxt   = r_ovf;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_res       = '0;
    w_res_c     = 1'b0;
    w_res_v     = 1'b0;
    w_fin       = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_fin = 1'b1;
          unique case (bus.op)
            3'b000: w_res = w_opa & bus.b;
            3'b001: w_res = w_opa | bus.b;
            3'b010: w_res = w_opa ^ bus.b;
            3'b011: w_res = ~w_opa;
            3'b100: begin
              w_res   = w_sum[WIDTH-1:0];
              w_res_c = w_sum[WIDTH];
              w_res_v = (w_opa[WIDTH-1] == bus.b[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != w_opa[WIDTH-1]);
            end
            3'b101: begin
              w_res   = w_diff[WIDTH-1:0];
              w_res_c = w_diff[WIDTH];
              w_res_v = (w_opa[WIDTH-1] != bus.b[WIDTH-1]) &&
                        (w_diff[WIDTH-1] != w_opa[WIDTH-1]);
            end
            default: begin
              // Shift/rotate by zero completes immediately with out = a.
              w_res = w_opa;
              if (w_cnt_in != '0) begin
                w_fin       = 1'b0;
                w_work_nxt  = w_opa;
                w_count_nxt = w_cnt_in;
                w_rot_nxt   = bus.op[0];
                w_busy_nxt  = 1'b1;
                w_state_nxt = S_SHIFT;
              end
            end
          endcase
        end
        if (w_fin) begin
          w_out_nxt   = w_res;
          w_zero_nxt  = (w_res == '0);
          w_neg_nxt   = w_res[WIDTH-1];
          w_carry_nxt = w_res_c;
          w_ovf_nxt   = w_res_v;
          w_done_nxt  = 1'b1;
        end
      end

      S_SHIFT: begin
        w_work_nxt  = w_step;
        w_carry_nxt = w_step_out;
        w_count_nxt = r_count - CW'(1);
        if (r_count == CW'(1)) begin
          w_out_nxt   = w_step;
          w_zero_nxt  = (w_step == '0);
          w_neg_nxt   = w_step[WIDTH-1];
          w_ovf_nxt   = 1'b0;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_work  <= '0;
      r_rot   <= 1'b0;
      r_out   <= '0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_work  <= w_work_nxt;
      r_rot   <= w_rot_nxt;
      r_out   <= w_out_nxt;
      r_zero  <= w_zero_nxt;
      r_neg   <= w_neg_nxt;
      r_carry <= w_carry_nxt;
      r_ovf   <= w_ovf_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.out     = r_out;
  assign bus.zero    = r_zero;
  assign bus.neg     = r_neg;
  assign bus.carry   = r_carry;
  assign bus.ovf     = r_ovf;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_ul_n_seq.sv
// Directed bench for ul_n_seq (WIDTH=8): logic/arith, iterative shifts, busy-ignore, reset abort, acc chaining.
module tb_ul_n_seq;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic dbg_state;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [5:0] flags;

  ul_n_seq_if #(.WIDTH(WIDTH)) bus ();

  ul_n_seq #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // {done, busy, zero, neg, carry, ovf}
  assign flags = {bus.done, bus.busy, bus.zero, bus.neg, bus.carry, bus.ovf};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_start(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                             input logic acc);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
`ifdef UL_N_SEQ_ACC_EN
    bus.acc   = acc;
`else
    if (acc) $display("note: acc requested without UL_N_SEQ_ACC_EN");
`endif
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.out, flags} !== 14'h0) begin
      n_errors++;
      $display("FAIL reset_outputs: got out=%h flags=%b expected out=00 flags=000000", bus.out, flags);
    end
    n_checks++;
    if (dbg_state !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: got %b expected 0", dbg_state);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.out, flags} !== 14'h0) begin
      n_errors++;
      $display("FAIL reset_release: got out=%h flags=%b expected out=00 flags=000000", bus.out, flags);
    end
  endtask

  task automatic test_add;
    drive_start(3'b100, 8'h7F, 8'h01, 1'b0);
    n_checks++;
    if (bus.out !== 8'h80) begin
      n_errors++;
      $display("FAIL add_out: got %h expected 80", bus.out);
    end
    n_checks++;
    if (flags !== 6'b100101) begin
      n_errors++;
      $display("FAIL add_flags: got %b expected 100101", flags);
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_errors++;
      $display("FAIL add_done_pulse: got %b expected 0", bus.done);
    end
  endtask

  task automatic test_sub;
    drive_start(3'b101, 8'h05, 8'h05, 1'b0);
    n_checks++;
    if (bus.out !== 8'h00) begin
      n_errors++;
      $display("FAIL sub_eq_out: got %h expected 00", bus.out);
    end
    n_checks++;
    if (flags !== 6'b101010) begin
      n_errors++;
      $display("FAIL sub_eq_flags: got %b expected 101010", flags);
    end
    drive_start(3'b101, 8'h03, 8'h04, 1'b0);
    n_checks++;
    if (bus.out !== 8'hFF) begin
      n_errors++;
      $display("FAIL sub_borrow_out: got %h expected ff", bus.out);
    end
    n_checks++;
    if (flags !== 6'b100100) begin
      n_errors++;
      $display("FAIL sub_borrow_flags: got %b expected 100100", flags);
    end
  endtask

  task automatic test_shl_busy;
    int cycles;
    logic got_done;
    cycles   = 0;
    got_done = 1'b0;
    drive_start(3'b110, 8'h81, 8'h03, 1'b0);
    n_checks++;
    if ({bus.busy, bus.done, dbg_state} !== 3'b101) begin
      n_errors++;
      $display("FAIL shl_load: got busy/done/state=%b%b%b expected 101", bus.busy, bus.done, dbg_state);
    end
    for (int i = 0; i < 20; i++) begin
      if (i == 0) begin
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cycles++;
      if (bus.done === 1'b1) begin
        got_done = 1'b1;
        break;
      end
      n_checks++;
      if (bus.busy !== 1'b1) begin
        n_errors++;
        $display("FAIL shl_busy: got %b expected 1 at cycle %0d", bus.busy, cycles);
      end
    end
    bus.start = 1'b0;
    n_checks++;
    if (!got_done || cycles != 3) begin
      n_errors++;
      $display("FAIL shl_latency: got done=%b after %0d cycles expected done after 3", got_done, cycles);
    end
    n_checks++;
    if (bus.out !== 8'h08) begin
      n_errors++;
      $display("FAIL shl_out: got %h expected 08", bus.out);
    end
    n_checks++;
    if (flags !== 6'b100000) begin
      n_errors++;
      $display("FAIL shl_flags: got %b expected 100000", flags);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.done, bus.out} !== {1'b0, 8'h08}) begin
      n_errors++;
      $display("FAIL shl_ignored_start: got done=%b out=%h expected done=0 out=08", bus.done, bus.out);
    end
  endtask

  task automatic test_ror;
    drive_start(3'b111, 8'h01, 8'h01, 1'b0);
    n_checks++;
    if ({bus.busy, bus.done} !== 2'b10) begin
      n_errors++;
      $display("FAIL ror_load: got busy/done=%b%b expected 10", bus.busy, bus.done);
    end
    @(negedge clk);
    n_checks++;
    if (bus.out !== 8'h80) begin
      n_errors++;
      $display("FAIL ror_out: got %h expected 80", bus.out);
    end
    n_checks++;
    if (flags !== 6'b100110) begin
      n_errors++;
      $display("FAIL ror_flags: got %b expected 100110", flags);
    end
    drive_start(3'b111, 8'h5A, 8'h08, 1'b0);
    n_checks++;
    if (bus.out !== 8'h5A) begin
      n_errors++;
      $display("FAIL ror_zero_count_out: got %h expected 5a", bus.out);
    end
    n_checks++;
    if ({flags, dbg_state} !== 7'b1000000) begin
      n_errors++;
      $display("FAIL ror_zero_count_flags: got %b state=%b expected 100000 state=0", flags, dbg_state);
    end
  endtask

  task automatic test_reset_during_shift;
    drive_start(3'b110, 8'hFF, 8'h07, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.out, bus.carry} !== {1'b1, 8'h5A, 1'b1}) begin
      n_errors++;
      $display("FAIL shift_midway: got busy=%b out=%h carry=%b expected busy=1 out=5a carry=1",
               bus.busy, bus.out, bus.carry);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.out, flags, dbg_state} !== 15'h0) begin
      n_errors++;
      $display("FAIL shift_reset_abort: got out=%h flags=%b state=%b expected all zero",
               bus.out, flags, dbg_state);
    end
    @(negedge clk);
    reset_n = 1'b1;
    drive_start(3'b000, 8'hF0, 8'h3C, 1'b0);
    n_checks++;
    if ({bus.done, bus.out} !== {1'b1, 8'h30}) begin
      n_errors++;
      $display("FAIL and_after_reset: got done=%b out=%h expected done=1 out=30", bus.done, bus.out);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] ops [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
    logic [7:0] va  [4] = '{8'hAA, 8'h50, 8'h0F, 8'hFF};
    logic [7:0] vb  [4] = '{8'h0F, 8'h0A, 8'h33, 8'h01};
    logic [7:0] ve  [4] = '{8'hA5, 8'h5A, 8'hF0, 8'h00};
    logic [7:0] exp_v;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.start = 1'b1;
      bus.op    = ops[i];
      bus.a     = va[i];
      bus.b     = vb[i];
`ifdef UL_N_SEQ_ACC_EN
      bus.acc   = 1'b0;
`endif
      exp_q.push_back(ve[i]);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({bus.done, bus.out} !== {1'b1, exp_v}) begin
        n_errors++;
        $display("FAIL b2b_%0d: got done=%b out=%h expected done=1 out=%h", i, bus.done, bus.out, exp_v);
      end
    end
    bus.start = 1'b0;
    n_checks++;
    if (flags !== 6'b101010) begin
      n_errors++;
      $display("FAIL b2b_add_wrap_flags: got %b expected 101010", flags);
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_done_drop: got %b expected 0", bus.done);
    end
  endtask

`ifdef UL_N_SEQ_ACC_EN
  task automatic test_acc;
    drive_start(3'b100, 8'h10, 8'h01, 1'b0);
    n_checks++;
    if (bus.out !== 8'h11) begin
      n_errors++;
      $display("FAIL acc_first: got %h expected 11", bus.out);
    end
    drive_start(3'b100, 8'h77, 8'h01, 1'b1);
    n_checks++;
    if (bus.out !== 8'h12) begin
      n_errors++;
      $display("FAIL acc_add: got %h expected 12", bus.out);
    end
    drive_start(3'b110, 8'h77, 8'h01, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({bus.done, bus.out} !== {1'b1, 8'h24}) begin
      n_errors++;
      $display("FAIL acc_shl: got done=%b out=%h expected done=1 out=24", bus.done, bus.out);
    end
    bus.acc = 1'b0;
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;
`ifdef UL_N_SEQ_ACC_EN
    bus.acc   = 1'b0;
`endif
    test_reset();
    test_add();
    test_sub();
    test_shl_busy();
    test_ror();
    test_reset_during_shift();
    test_back_to_back();
`ifdef UL_N_SEQ_ACC_EN
    test_acc();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
